pe_acc_pipe: RTL and testbench
==============================

PE_ACC_PIPE -- requirements
Module: pe_acc_pipe

Interface
REQ-001 SHALL have parameter LANES, default 32: number of signed products per beat; power of two, 2..64.
REQ-002 SHALL have parameter IN_W, default 32: width of each product lane.
REQ-003 SHALL have parameter ACC_W, default 48: accumulator width; at least IN_W+log2(LANES).
REQ-004 SHALL have parameter OUT_W, default 32: result width; at most ACC_W.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports: clk  in  1  clock, all logic on rising edge; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: mult_result  in  LANES*IN_W  products, lane j at bits [j*IN_W +: IN_W], two's complement.
REQ-007 SHALL have ports: in_valid  in  1  beat present; in_last  in  1  beat closes the group; in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-008 SHALL have ports: acc_result  out  OUT_W  group sum; acc_beats  out  16  beats in group; acc_sat  out  1  result clipped; out_valid  out  1; out_ready  in  1.

Function
REQ-009 SHALL compute, per accepted beat, the signed sum of all LANES lanes in a binary tree of log2(LANES) levels, each level registered; level sums SHALL sign-extend by one bit per level, without loss.
REQ-010 SHALL add each tree sum, sign-extended to ACC_W, into a running accumulator one stage after the last tree level; accumulator arithmetic SHALL wrap modulo 2^ACC_W.
REQ-011 SHALL, when the beat carrying in_last reaches the accumulate stage, load the group total into the output register, set out_valid, and clear the accumulator so the next beat starts a new group from zero.
REQ-012 SHALL have latency log2(LANES)+1 cycles from acceptance of a last beat to out_valid high, absent stalls (6 cycles at LANES=32).
REQ-013 SHALL sustain one beat per cycle; a single-beat group (in_last on first beat) SHALL be legal.
REQ-014 SHALL hold acc_result, acc_beats, acc_sat, out_valid stable while out_valid && !out_ready.
REQ-015 SHALL drive in_ready = !(out_valid && !out_ready) and freeze every pipeline stage and the accumulator while in_ready is low.
REQ-016 SHALL clear out_valid on out_valid && out_ready unless a new last beat completes in the same cycle, in which case the output register SHALL reload and out_valid SHALL stay high.
REQ-017 SHALL propagate valid and last flags alongside data through every stage; bubbles (in_valid low) SHALL NOT alter the accumulator.
REQ-018 SHALL count accepted beats per group in acc_beats, saturating at 65535.
REQ-019 SHALL, without PE_ACC_SAT_EN, drive acc_result as the low OUT_W bits of the total and hold acc_sat at 0.

Reset
REQ-020 SHALL, on rst, clear all pipeline valids, the accumulator, beat counter, out_valid, acc_result, acc_beats, and acc_sat to 0 on the same edge.
REQ-021 SHALL discard any partial group in flight at reset; in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-022 SHALL, with macro PE_ACC_SAT_EN defined, clamp the ACC_W total to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set acc_sat when clamping occurs; without it, truncate per REQ-019.

Verification
REQ-023 SHALL be tested so that: LANES=32, all lanes = 1, single beat with last -> acc_result=32, acc_beats=1, out_valid exactly 6 cycles after acceptance.
REQ-024 SHALL be tested so that: 4 back-to-back beats, lane j = j-16 each beat, last on 4th -> acc_result=-64, acc_beats=4, in_ready constantly 1.
REQ-025 SHALL be tested so that: out_ready held 0 for 5 cycles with a result pending while beats stream -> in_ready=0, output stable, no beat lost; after release the next group sum is correct.
REQ-026 SHALL be tested so that: two single-beat groups with out_ready=1 accepted on consecutive cycles -> out_valid high 2 consecutive cycles with sums of each group, no merge.
REQ-027 SHALL be tested so that: all lanes = 0x7FFFFFFF, 2 beats -> without macro acc_result=0xFFFFFFC0, acc_sat=0; with PE_ACC_SAT_EN acc_result=0x7FFFFFFF, acc_sat=1.
REQ-028 SHALL be tested so that: rst asserted mid-group after 3 beats, then a 1-beat group of ones -> acc_result=32, acc_beats=1.

Source files
------------

// File: rtl/pe_acc_pipe.sv
// pe_acc_pipe: sums LANES signed products per beat in a registered adder tree, then accumulates beats into per-group totals.
// Latency: log2(LANES)+1 cycles from acceptance of a last beat to out_valid (input register, log2(LANES) tree levels, accumulate).
// Backpressure: in_ready drops while a result waits unaccepted; every stage and the accumulator freeze. Macro PE_ACC_SAT_EN clamps instead of truncating.
module pe_acc_pipe #(
  parameter int LANES = 32,
  parameter int IN_W  = 32,
  parameter int ACC_W = 48,
  parameter int OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*IN_W-1:0] mult_result,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      acc_result,
  output logic [15:0]           acc_beats,
  output logic                  acc_sat,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int LEVELS = $clog2(LANES);

  // The whole pipe moves only when the output register can take a new result.
  logic adv;
  assign in_ready = !(out_valid && !out_ready);
  assign adv      = in_ready;

  // Level 0 is the registered input beat; level l holds LANES>>l partial sums, each IN_W+l bits wide.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = LANES >> l;
    localparam int W = IN_W + l;
    logic [N*W-1:0] dat;
    logic           vld;
    logic           lst;
    if (l == 0) begin : g_in
      // Capture the offered beat; a bubble enters the pipe with vld low.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld <= 1'b0;
          lst <= 1'b0;
        end else if (adv) begin
          vld <= in_valid;
          lst <= in_valid && in_last;
          dat <= mult_result;
        end
      end
    end else begin : g_add
      // Pairwise add of the previous level, each operand sign-extended by one bit so no carry is lost.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld <= 1'b0;
          lst <= 1'b0;
        end else if (adv) begin
          vld <= g_lvl[l-1].vld;
          lst <= g_lvl[l-1].lst;
          for (int k = 0; k < N; k++) begin
            dat[k*W +: W] <= W'($signed(g_lvl[l-1].dat[(2*k)*(W-1) +: W-1]))
                           + W'($signed(g_lvl[l-1].dat[(2*k+1)*(W-1) +: W-1]));
          end
        end
      end
    end
  end

  logic                    top_vld;
  logic                    top_lst;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [15:0]             beat_cnt;
  logic [15:0]             beat_nxt;
  logic [OUT_W-1:0]        res_nxt;
  logic                    sat_nxt;

  assign top_vld = g_lvl[LEVELS].vld;
  assign top_lst = g_lvl[LEVELS].lst;

  // Running total including the beat now leaving the tree (wraps modulo 2^ACC_W), and its saturating beat count.
  always_comb begin
    acc_sum  = acc + ACC_W'($signed(g_lvl[LEVELS].dat));
    beat_nxt = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
  end

`ifdef PE_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp the full-width total into the signed OUT_W range and flag when clipping happened.
  always_comb begin
    res_nxt = acc_sum[OUT_W-1:0];
    sat_nxt = 1'b0;
    if (acc_sum > SAT_MAX) begin
      res_nxt = SAT_MAX[OUT_W-1:0];
      sat_nxt = 1'b1;
    end else if (acc_sum < SAT_MIN) begin
      res_nxt = SAT_MIN[OUT_W-1:0];
      sat_nxt = 1'b1;
    end
  end
`else
  // Plain truncation to the low OUT_W bits; never reports clipping.
  always_comb begin
    res_nxt = acc_sum[OUT_W-1:0];
    sat_nxt = 1'b0;
  end
`endif

  // Accumulate stage: add valid beats, close the group on last, hand the result to the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      acc_result <= '0;
      acc_beats  <= '0;
      acc_sat    <= 1'b0;
    end else begin
      if (adv && top_vld) begin
        if (top_lst) begin
          acc        <= '0;
          beat_cnt   <= '0;
          acc_result <= res_nxt;
          acc_beats  <= beat_nxt;
          acc_sat    <= sat_nxt;
        end else begin
          acc      <= acc_sum;
          beat_cnt <= beat_nxt;
        end
      end
      // A completing group keeps out_valid high even while the old result is being taken.
      if (adv && top_vld && top_lst) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_acc_pipe.sv
// tb_pe_acc_pipe: scoreboard bench for pe_acc_pipe at default parameters.
// Expected group results are pushed when the last beat is offered and popped when the output handshakes.
// Define PE_ACC_SAT_EN for both bench and RTL to exercise the clamping build.
module tb_pe_acc_pipe;
  localparam int LANES = 32;
  localparam int IN_W  = 32;
  localparam int ACC_W = 48;
  localparam int OUT_W = 32;
  localparam int BUS   = LANES * IN_W;
  localparam int LAT   = $clog2(LANES) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [BUS-1:0]   mult_result = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] acc_result;
  logic [15:0]      acc_beats;
  logic             acc_sat;
  logic             out_valid;
  logic             out_ready = 1'b1;

  pe_acc_pipe #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .mult_result(mult_result), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .acc_result(acc_result), .acc_beats(acc_beats), .acc_sat(acc_sat),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] res;
    logic [15:0]      beats;
    logic             sat;
  } exp_t;

  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [ACC_W-1:0] m_acc = '0;
  int               m_beats = 0;

  function automatic logic [BUS-1:0] all_lanes(input logic [IN_W-1:0] v);
    logic [BUS-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*IN_W +: IN_W] = v;
    return r;
  endfunction

  function automatic logic [BUS-1:0] ramp_lanes();
    logic [BUS-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*IN_W +: IN_W] = IN_W'(j - 16);
    return r;
  endfunction

  function automatic logic [BUS-1:0] rnd_lanes();
    logic [BUS-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*IN_W +: IN_W] = $urandom;
    return r;
  endfunction

  // Reference model: lane sum, wrapping accumulator, group close with truncate or clamp.
  function automatic void model_beat(input logic [BUS-1:0] d, input bit last);
    longint s = 0;
    longint tl;
    exp_t   e;
    for (int j = 0; j < LANES; j++) s += longint'($signed(d[j*IN_W +: IN_W]));
    m_acc   = m_acc + ACC_W'(s);
    m_beats = (m_beats < 65535) ? m_beats + 1 : 65535;
    if (last) begin
      tl      = longint'($signed(m_acc));
      e.res   = OUT_W'(tl);
      e.beats = 16'(m_beats);
      e.sat   = 1'b0;
`ifdef PE_ACC_SAT_EN
      if (tl > (longint'(1) <<< (OUT_W-1)) - 1) begin
        e.res = OUT_W'((longint'(1) <<< (OUT_W-1)) - 1);
        e.sat = 1'b1;
      end else if (tl < -(longint'(1) <<< (OUT_W-1))) begin
        e.res = OUT_W'(-(longint'(1) <<< (OUT_W-1)));
        e.sat = 1'b1;
      end
`endif
      sb.push_back(e);
      m_acc   = '0;
      m_beats = 0;
    end
  endfunction

  // Output monitor: scoreboard pop on handshake, and stability of a result held under backpressure.
  initial begin
    exp_t e;
    exp_t prev_out;
    bit   hold_prev;
    hold_prev = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          vectors++;
          if ({out_valid, acc_result, acc_beats, acc_sat} !== {1'b1, prev_out}) begin
            miscompares++;
            $display("FAIL hold_stable: got valid=%0b res=%h beats=%0d sat=%0b, expected held res=%h beats=%0d sat=%0b",
                     out_valid, acc_result, acc_beats, acc_sat, prev_out.res, prev_out.beats, prev_out.sat);
          end
        end
        if (out_valid && out_ready) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got res=%h beats=%0d with nothing expected", acc_result, acc_beats);
          end else begin
            e = sb.pop_front();
            if ({acc_result, acc_beats, acc_sat} !== e) begin
              miscompares++;
              $display("FAIL sb_result: got res=%h beats=%0d sat=%0b, expected res=%h beats=%0d sat=%0b",
                       acc_result, acc_beats, acc_sat, e.res, e.beats, e.sat);
            end
          end
        end
        hold_prev = out_valid && !out_ready;
        prev_out  = {acc_result, acc_beats, acc_sat};
      end
    end
  end

  // Offer one beat from a negedge until accepted; waited reports how many cycles in_ready was low.
  task automatic send_beat(input logic [BUS-1:0] d, input bit last, output int waited);
    int n;
    n = 0;
    @(negedge clk);
    mult_result = d;
    in_valid    = 1'b1;
    in_last     = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
    end else begin
      model_beat(d, last);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL valid_timeout: out_valid=%0b after %0d cycles, expected 1", out_valid, n);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results still expected, out_valid=%0b, expected 0", sb.size(), out_valid);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_acc   = '0;
    m_beats = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    vectors++;
    if ({out_valid, acc_result, acc_beats, acc_sat} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b res=%h beats=%0d sat=%0b, expected all 0",
               out_valid, acc_result, acc_beats, acc_sat);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %0b, expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    int w;
    int n;
    send_beat(all_lanes(32'd1), 1'b1, w);
    wait_valid(n);
    vectors++;
    if (n !== LAT) begin
      miscompares++;
      $display("FAIL single_latency: got %0d cycles, expected %0d", n, LAT);
    end
    vectors++;
    if (acc_result !== 32'd32 || acc_beats !== 16'd1) begin
      miscompares++;
      $display("FAIL single_value: got res=%h beats=%0d, expected res=00000020 beats=1", acc_result, acc_beats);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int w;
    int n;
    for (int i = 0; i < 4; i++) begin
      send_beat(ramp_lanes(), i == 3, w);
      vectors++;
      if (w !== 0) begin
        miscompares++;
        $display("FAIL b2b_in_ready: beat %0d waited %0d cycles, expected 0", i, w);
      end
    end
    wait_valid(n);
    vectors++;
    if (acc_result !== 32'hFFFFFFC0 || acc_beats !== 16'd4) begin
      miscompares++;
      $display("FAIL b2b_value: got res=%h beats=%0d, expected res=ffffffc0 beats=4", acc_result, acc_beats);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    int w;
    out_ready = 1'b0;
    send_beat(all_lanes(32'd1), 1'b1, w);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int wi;
          send_beat(rnd_lanes(), i == 7, wi);
        end
      end
      begin
        int n;
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
          @(posedge clk);
          #1;
          vectors++;
          if (in_ready !== 1'b0 || acc_result !== 32'd32) begin
            miscompares++;
            $display("FAIL stall_hold: cycle %0d in_ready=%0b res=%h, expected in_ready=0 res=00000020",
                     i, in_ready, acc_result);
          end
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_consecutive_groups();
    int w;
    int n;
    send_beat(all_lanes(32'd5), 1'b1, w);
    send_beat(all_lanes(32'hFFFFFFFD), 1'b1, w);
    wait_valid(n);
    vectors++;
    if (acc_result !== 32'd160) begin
      miscompares++;
      $display("FAIL consec_first: got res=%h, expected 000000a0", acc_result);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || acc_result !== 32'hFFFFFFA0) begin
      miscompares++;
      $display("FAIL consec_second: got valid=%0b res=%h, expected valid=1 res=ffffffa0", out_valid, acc_result);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL consec_drop: got out_valid=%0b, expected 0", out_valid);
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    int               w;
    int               n;
    logic [OUT_W-1:0] exp_res;
    logic             exp_sat;
`ifdef PE_ACC_SAT_EN
    exp_res = 32'h7FFFFFFF;
    exp_sat = 1'b1;
`else
    exp_res = 32'hFFFFFFC0;
    exp_sat = 1'b0;
`endif
    send_beat(all_lanes(32'h7FFFFFFF), 1'b0, w);
    send_beat(all_lanes(32'h7FFFFFFF), 1'b1, w);
    wait_valid(n);
    vectors++;
    if (acc_result !== exp_res || acc_sat !== exp_sat || acc_beats !== 16'd2) begin
      miscompares++;
      $display("FAIL sat_value: got res=%h sat=%0b beats=%0d, expected res=%h sat=%0b beats=2",
               acc_result, acc_sat, acc_beats, exp_res, exp_sat);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_group();
    int w;
    int n;
    for (int i = 0; i < 3; i++) send_beat(rnd_lanes(), 1'b0, w);
    do_reset();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: got in_ready=%0b out_valid=%0b, expected in_ready=1 out_valid=0", in_ready, out_valid);
    end
    send_beat(all_lanes(32'd1), 1'b1, w);
    wait_valid(n);
    vectors++;
    if (acc_result !== 32'd32 || acc_beats !== 16'd1) begin
      miscompares++;
      $display("FAIL midrst_value: got res=%h beats=%0d, expected res=00000020 beats=1", acc_result, acc_beats);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_consecutive_groups();
    test_saturation();
    test_reset_mid_group();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
